// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// UART transmitter draining a registered-output FIFO; `FIFO_UART_TX_PARITY_EN adds an even-parity bit.
// Latency: 3 edges from IDLE sampling fifo_empty=0 to tx falling; frame (2+DATA_WIDTH[+1])*CLK_DIV cycles.
// Backpressure: fifo_empty is sampled only in IDLE, so at most one word is popped per frame.
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_re,
    output logic                  tx,
    output logic                  busy
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
        , S_PARITY = 3'd6
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BAUD_W-1:0]     r_baud;
    logic [2:0]            r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_bit_end;
    logic                  w_last_bit;
    logic                  w_in_bit;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_last_bit = (r_bit == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!fifo_empty) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_START;
            S_START: if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && w_last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
            S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_re  = (r_state == S_FETCH);
        busy     = (r_state != S_IDLE);
        w_in_bit = 1'b0;
        tx       = 1'b1;
        case (r_state)
            S_START: begin
                w_in_bit = 1'b1;
                tx       = 1'b0;
            end
            S_DATA: begin
                w_in_bit = 1'b1;
                tx       = r_shift[0];
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                w_in_bit = 1'b1;
                tx       = r_parity;
            end
`endif
            S_STOP: w_in_bit = 1'b1;
            default: ;
        endcase
    end

    // fifo_q is valid in WAIT, one cycle after the pop issued in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (r_state == S_WAIT) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= fifo_q;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= ^fifo_q;
`endif
        end else if (w_in_bit) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_state == S_DATA) begin
                    r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                    r_bit   <= w_last_bit ? 3'd0 : r_bit + 3'd1;
                end
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
        end else begin
            r_baud <= '0;
            r_bit  <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// Directed bench for fifo_uart_tx with a behavioural registered-read FIFO on its read port.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME = 44;
    localparam logic [47:0] W55 = 48'hF00F0F0F0F0;
    localparam logic [47:0] WA5 = 48'hF0F0F00F0F0;
    localparam logic [47:0] W3C = 48'hF000FFFF000;
    localparam logic [47:0] W07 = 48'hFF00000FFF0;
    localparam logic [47:0] W22 = 48'hF000F000F00;
    localparam logic [47:0] W81 = 48'hF0F000000F0;
    localparam logic [47:0] W42 = 48'hF00F0000F00;
`else
    localparam int FRAME = 40;
    localparam logic [47:0] W55 = 48'hF0F0F0F0F0;
    localparam logic [47:0] WA5 = 48'hFF0F00F0F0;
    localparam logic [47:0] W3C = 48'hF00FFFF000;
    localparam logic [47:0] W07 = 48'hF00000FFF0;
    localparam logic [47:0] W22 = 48'hF00F000F00;
    localparam logic [47:0] W81 = 48'hFF000000F0;
    localparam logic [47:0] W42 = 48'hF0F0000F00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold_empty = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_re;
    logic       tx;
    logic       busy;

    logic [7:0] mem [16];
    logic [4:0] wr_ptr = 5'd0;
    logic [4:0] rd_ptr = 5'd0;
    int         re_cnt = 0;
    int         underflow = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

    always @(posedge clk) begin
        if (fifo_re) begin
            re_cnt <= re_cnt + 1;
            fifo_q <= mem[rd_ptr[3:0]];
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
            else rd_ptr <= rd_ptr + 5'd1;
        end
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy)
    );

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (tx === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic capture(output logic [47:0] wave, output logic all_busy);
        wave = '0;
        all_busy = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            wave[c] = tx;
            if (busy !== 1'b1) all_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", fifo_re); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL empty_idle bad_cycles got %0d exp 0", bad); end
        checks++; if (re_cnt !== 0) begin errors++; $display("FAIL empty_idle re_pulses got %0d exp 0", re_cnt); end
    endtask

    task automatic test_single;
        int base;
        logic [47:0] wave;
        logic ab;
        base = re_cnt;
        push(8'h55);
        @(negedge clk);
        checks++; if (fifo_re !== 1'b1) begin errors++; $display("FAIL single_fetch_re got %b exp 1", fifo_re); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_fetch_busy got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL single_wait_re got %b exp 0", fifo_re); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_wait_tx got %b exp 1", tx); end
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_tx got %b exp 0", tx); end
        capture(wave, ab);
        checks++; if (wave !== W55) begin errors++; $display("FAIL single_wave got %h exp %h", wave, W55); end
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL single_busy_frame got %b exp 1", ab); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got %b exp 1", tx); end
        checks++; if (re_cnt - base !== 1) begin errors++; $display("FAIL single_re_pulses got %0d exp 1", re_cnt - base); end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [47:0] wave;
        logic ab, ok, gap_ok;
        base = re_cnt;
        push(8'hA5);
        push(8'h3C);
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_start1 timeout got %b exp 1", ok); end
        capture(wave, ab);
        checks++; if (wave !== WA5) begin errors++; $display("FAIL b2b_wave1 got %h exp %h", wave, WA5); end
        gap_ok = 1'b1;
        for (int g = 0; g < 3; g++) begin
            if (tx !== 1'b1) gap_ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL b2b_gap_high got %b exp 1", gap_ok); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start2 got %b exp 0", tx); end
        capture(wave, ab);
        checks++; if (wave !== W3C) begin errors++; $display("FAIL b2b_wave2 got %h exp %h", wave, W3C); end
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
        checks++; if (re_cnt - base !== 2) begin errors++; $display("FAIL b2b_re_pulses got %0d exp 2", re_cnt - base); end
    endtask

    task automatic test_reset_mid_frame;
        int base, bad;
        logic ok;
        base = re_cnt;
        push(8'hFF);
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_start timeout got %b exp 1", ok); end
        repeat (17) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_bit3_busy got %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL rstmid_re got %b exp 0", fifo_re); end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", bad); end
        checks++; if (re_cnt - base !== 1) begin errors++; $display("FAIL rstmid_re_pulses got %0d exp 1", re_cnt - base); end
    endtask

    task automatic test_reset_fetch;
        int base;
        logic [47:0] wave;
        logic ab, ok;
        base = re_cnt;
        push(8'h11);
        push(8'h22);
        @(negedge clk);
        checks++; if (fifo_re !== 1'b1) begin errors++; $display("FAIL rstfetch_re got %b exp 1", fifo_re); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstfetch_busy got %b exp 0", busy); end
        checks++; if (re_cnt - base !== 1) begin errors++; $display("FAIL rstfetch_pop got %0d exp 1", re_cnt - base); end
        rst = 1'b0;
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstfetch_start timeout got %b exp 1", ok); end
        capture(wave, ab);
        checks++; if (wave !== W22) begin errors++; $display("FAIL rstfetch_wave got %h exp %h", wave, W22); end
        repeat (20) @(negedge clk);
        checks++; if (re_cnt - base !== 2) begin errors++; $display("FAIL rstfetch_re_pulses got %0d exp 2", re_cnt - base); end
    endtask

    task automatic test_parity_width;
        logic [47:0] wave;
        logic ab, ok;
        push(8'h07);
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL par_start timeout got %b exp 1", ok); end
        capture(wave, ab);
        checks++; if (wave !== W07) begin errors++; $display("FAIL par_wave got %h exp %h", wave, W07); end
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL par_busy_frame got %b exp 1", ab); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_frame_len busy got %b exp 0", busy); end
    endtask

    task automatic test_empty_toggle;
        int base, bad;
        logic [47:0] wave;
        logic ab, ok;
        base = re_cnt;
        push(8'h81);
        push(8'h42);
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tog_start timeout got %b exp 1", ok); end
        wave = '0;
        for (int c = 0; c < FRAME; c++) begin
            hold_empty = (c % 2 == 1);
            wave[c] = tx;
            @(negedge clk);
        end
        hold_empty = 1'b1;
        checks++; if (wave !== W81) begin errors++; $display("FAIL tog_wave1 got %h exp %h", wave, W81); end
        checks++; if (re_cnt - base !== 1) begin errors++; $display("FAIL tog_re_in_frame got %0d exp 1", re_cnt - base); end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tog_held_idle got %0d exp 0", bad); end
        hold_empty = 1'b0;
        @(negedge clk);
        checks++; if (fifo_re !== 1'b1) begin errors++; $display("FAIL tog_re_after_release got %b exp 1", fifo_re); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tog_start2 got %b exp 0", tx); end
        capture(wave, ab);
        checks++; if (wave !== W42) begin errors++; $display("FAIL tog_wave2 got %h exp %h", wave, W42); end
        checks++; if (re_cnt - base !== 2) begin errors++; $display("FAIL tog_re_pulses got %0d exp 2", re_cnt - base); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_fetch();
        test_parity_width();
        test_empty_toggle();
        checks++; if (underflow !== 0) begin errors++; $display("FAIL underflow got %0d exp 0", underflow); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
